// File: rtl/sixbit_align_ctrl.sv
// -----------------------------------------------------------------------------
// sixbit_align_ctrl
//
// Word-alignment controller for an 8b6b link. It hunts for a bit position at
// which the decoder produces only in-table characters. On a bad character it
// requests a one-bit deserializer slip, waits for the pipeline to settle, and
// hunts again. Once LOCK_COUNT consecutive good characters are seen the link is
// declared locked. It stays locked until UNLOCK_ERRS not-in-table characters
// fall inside one WINDOW-character window.
//
// Ports
//   clock        in   1  frame clock, all logic on its rising edge
//   reset        in   1  synchronous, active-high
//   enable       in   1  alignment enable; low parks the FSM in HUNT
//   frame_valid  in   1  decoder outputs are valid this clock
//   not_in_table in   1  decoder flagged the character as not in the table
//   bitslip      out  1  one-clock request for a one-bit deserializer slip
//   locked       out  1  link aligned (state == LOCKED)
//   state        out  2  SLIP=0, WAIT=1, HUNT=2, LOCKED=3
//   slip_pos     out  3  slips issued since reset, modulo 8
//   unlock_cnt   out  8  LOCKED-to-SLIP transitions, saturating
//   err_cnt      out 16  not-in-table characters seen while locked, saturating
//
// Build option
//   ALIGN_ERR_COUNTER_EN  when defined, err_cnt is a live saturating counter;
//                         when undefined, err_cnt is tied to zero and the
//                         counter does not exist.
// -----------------------------------------------------------------------------
module sixbit_align_ctrl #(
    parameter int LOCK_COUNT  = 64,
    parameter int UNLOCK_ERRS = 4,
    parameter int WINDOW      = 256,
    parameter int SLIP_WAIT   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_valid,
    input  logic        not_in_table,
    output logic        bitslip,
    output logic        locked,
    output logic [1:0]  state,
    output logic [2:0]  slip_pos,
    output logic [7:0]  unlock_cnt,
    output logic [15:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        ST_SLIP   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                bitslip_q;
    logic                locked_q;
    logic [2:0]          slip_pos_q, slip_pos_d;
    logic [7:0]          unlock_cnt_q, unlock_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0]    win_err_q, win_err_d;
    logic [ERR_W-1:0]    win_err_nxt_s;
    logic                good_char_s;
    logic                bad_char_s;

    assign good_char_s = frame_valid & ~not_in_table;
    assign bad_char_s  = frame_valid &  not_in_table;

    // Next-state and counter update logic for the alignment FSM.
    always_comb begin
        state_d       = state_q;
        slip_pos_d    = slip_pos_q;
        unlock_cnt_d  = unlock_cnt_q;
        good_cnt_d    = good_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        win_cnt_d     = win_cnt_q;
        win_err_d     = win_err_q;
        win_err_nxt_s = win_err_q;

        if (!enable) begin
            // Disabled: park in HUNT with clean character counters so that a
            // later enable resumes hunting at the current slip position.
            state_d    = ST_HUNT;
            good_cnt_d = {GOOD_W{1'b0}};
            wait_cnt_d = {WAIT_W{1'b0}};
            win_cnt_d  = {WIN_W{1'b0}};
            win_err_d  = {ERR_W{1'b0}};
        end else begin
            case (state_q)
                ST_SLIP: begin
                    slip_pos_d = slip_pos_q + 3'd1;
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    // Settling time counts clocks, not characters.
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_d    = ST_HUNT;
                        wait_cnt_d = {WAIT_W{1'b0}};
                        good_cnt_d = {GOOD_W{1'b0}};
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_HUNT: begin
                    // A bad character is checked first so that an error on
                    // the would-be locking character still forces a slip.
                    if (bad_char_s) begin
                        state_d    = ST_SLIP;
                        good_cnt_d = {GOOD_W{1'b0}};
                    end else if (good_char_s) begin
                        if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = {GOOD_W{1'b0}};
                            win_cnt_d  = {WIN_W{1'b0}};
                            win_err_d  = {ERR_W{1'b0}};
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        good_cnt_d = good_cnt_q;
                    end
                end
                ST_LOCKED: begin
                    if (frame_valid) begin
                        // The character that closes a window opens the next
                        // one, so its error (if any) seeds the new window.
                        if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                            win_cnt_d     = {WIN_W{1'b0}};
                            win_err_nxt_s = ERR_W'(not_in_table);
                        end else begin
                            win_cnt_d     = win_cnt_q + WIN_W'(1);
                            win_err_nxt_s = win_err_q + ERR_W'(not_in_table);
                        end
                        if (win_err_nxt_s == ERR_W'(UNLOCK_ERRS)) begin
                            state_d   = ST_SLIP;
                            win_cnt_d = {WIN_W{1'b0}};
                            win_err_d = {ERR_W{1'b0}};
                            if (unlock_cnt_q != 8'hFF) begin
                                unlock_cnt_d = unlock_cnt_q + 8'd1;
                            end else begin
                                unlock_cnt_d = unlock_cnt_q;
                            end
                        end else begin
                            win_err_d = win_err_nxt_s;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            slip_pos_q   <= 3'd0;
            unlock_cnt_q <= 8'd0;
            good_cnt_q   <= {GOOD_W{1'b0}};
            wait_cnt_q   <= {WAIT_W{1'b0}};
            win_cnt_q    <= {WIN_W{1'b0}};
            win_err_q    <= {ERR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            // Outputs are decoded from the next state so they are flops that
            // always agree with the state register.
            bitslip_q    <= (state_d == ST_SLIP);
            locked_q     <= (state_d == ST_LOCKED);
            slip_pos_q   <= slip_pos_d;
            unlock_cnt_q <= unlock_cnt_d;
            good_cnt_q   <= good_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
        end
    end

`ifdef ALIGN_ERR_COUNTER_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of bad characters sampled while locked.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (enable && (state_q == ST_LOCKED) && bad_char_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign state      = state_q;
    assign slip_pos   = slip_pos_q;
    assign unlock_cnt = unlock_cnt_q;

endmodule

// File: tb/tb_sixbit_align_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sixbit_align_ctrl (default parameters).
// Expected output snapshots are queued as stimulus is driven, tagged with the
// clock at which they must hold, and compared when that clock's outputs settle.
// -----------------------------------------------------------------------------
module tb_sixbit_align_ctrl;

    localparam int ST_SLIP   = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_HUNT   = 2;
    localparam int ST_LOCKED = 3;

`ifdef ALIGN_ERR_COUNTER_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        enable;
    logic        frame_valid;
    logic        not_in_table;
    logic        bitslip;
    logic        locked;
    logic [1:0]  state;
    logic [2:0]  slip_pos;
    logic [7:0]  unlock_cnt;
    logic [15:0] err_cnt;

    sixbit_align_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .frame_valid  (frame_valid),
        .not_in_table (not_in_table),
        .bitslip      (bitslip),
        .locked       (locked),
        .state        (state),
        .slip_pos     (slip_pos),
        .unlock_cnt   (unlock_cnt),
        .err_cnt      (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string tag;
        int    cyc;
        int    st;
        int    bs;
        int    lk;
        int    sp;
        int    uc;
        int    ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   pulse_cnt = 0;

    function automatic int e(int n);
        return ERR_EN ? n : 0;
    endfunction

    // Single comparison point.
    task automatic chk(string tag, int obs, int exp_v);
        n_chk++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Queue an expected snapshot for the outputs after the next clock edge.
    task automatic push_exp(string tag, int st, int bs, int lk, int sp, int uc, int ec);
        exp_t x;
        x.tag = tag; x.cyc = cyc + 1;
        x.st = st; x.bs = bs; x.lk = lk; x.sp = sp; x.uc = uc; x.ec = ec;
        exp_q.push_back(x);
    endtask

    task automatic compare_due();
        exp_t x;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            x = exp_q.pop_front();
            chk({x.tag, ".state"},      int'(state),      x.st);
            chk({x.tag, ".bitslip"},    int'(bitslip),    x.bs);
            chk({x.tag, ".locked"},     int'(locked),     x.lk);
            chk({x.tag, ".slip_pos"},   int'(slip_pos),   x.sp);
            chk({x.tag, ".unlock_cnt"}, int'(unlock_cnt), x.uc);
            chk({x.tag, ".err_cnt"},    int'(err_cnt),    x.ec);
        end
    endtask

    // Drive one clock of stimulus, then sample settled outputs.
    task automatic step(bit en, bit fv, bit nit);
        enable       = en;
        frame_valid  = fv;
        not_in_table = nit;
        @(posedge clock);
        #1;
        cyc++;
        if (bitslip) pulse_cnt++;
        compare_due();
    endtask

    task automatic run(int n, bit fv, bit nit);
        for (int i = 0; i < n; i++) step(1'b1, fv, nit);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; frame_valid = 1'b0; not_in_table = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        push_exp("reset", ST_HUNT, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1);
        reset = 1'b0;

        // Lock after 64 good characters; invalid clocks carry no weight
        run(30, 1'b1, 1'b0);
        run(5, 1'b0, 1'b1);
        run(32, 1'b1, 1'b0);
        push_exp("hunt63", ST_HUNT, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        push_exp("lock64", ST_LOCKED, 0, 1, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("no_slip_lock", pulse_cnt, 0);

        // Four errors spread inside one window: unlock
        for (int i = 1; i <= 200; i++) begin
            if (i == 199) push_exp("three_errs", ST_LOCKED, 0, 1, 0, 0, e(3));
            if (i == 200) push_exp("unlock", ST_SLIP, 1, 0, 0, 1, e(4));
            step(1'b1, 1'b1, (i == 5 || i == 50 || i == 120 || i == 200));
        end
        // WAIT ignores bad characters and lasts SLIP_WAIT clocks
        push_exp("wait1", ST_WAIT, 0, 0, 1, 1, e(4));
        step(1'b1, 1'b1, 1'b1);
        run(6, 1'b1, 1'b1);
        push_exp("wait8", ST_WAIT, 0, 0, 1, 1, e(4));
        step(1'b1, 1'b1, 1'b1);
        push_exp("hunt_after_wait", ST_HUNT, 0, 0, 1, 1, e(4));
        step(1'b1, 1'b0, 1'b0);
        chk("pulses_unlock", pulse_cnt, 1);

        // HUNT error after 10 good characters, then relock
        run(10, 1'b1, 1'b0);
        push_exp("hunt_err", ST_SLIP, 1, 0, 1, 1, e(4));
        step(1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b0);
        push_exp("hunt_again", ST_HUNT, 0, 0, 2, 1, e(4));
        step(1'b1, 1'b0, 1'b0);
        run(63, 1'b1, 1'b0);
        push_exp("relock", ST_LOCKED, 0, 1, 2, 1, e(4));
        step(1'b1, 1'b1, 1'b0);

        // Three errors per window for ten windows: stays locked
        for (int w = 0; w < 10; w++) begin
            for (int p = 1; p <= 256; p++) begin
                if (w == 9 && p == 256) push_exp("ten_windows", ST_LOCKED, 0, 1, 2, 1, e(34));
                step(1'b1, 1'b1, (p == 10 || p == 100 || p == 200));
            end
        end
        // Error on the window-closing character counts once in the new window
        for (int p = 1; p <= 256; p++) begin
            if (p == 256) push_exp("boundary_err", ST_LOCKED, 0, 1, 2, 1, e(38));
            step(1'b1, 1'b1, (p == 100 || p == 200 || p == 255 || p == 256));
        end
        step(1'b1, 1'b1, 1'b1);
        push_exp("two_more", ST_LOCKED, 0, 1, 2, 1, e(40));
        step(1'b1, 1'b1, 1'b1);
        push_exp("third_more", ST_SLIP, 1, 0, 2, 2, e(41));
        step(1'b1, 1'b1, 1'b1);

        // Error on the would-be locking character wins
        run(8, 1'b0, 1'b0);
        push_exp("hunt3", ST_HUNT, 0, 0, 3, 2, e(41));
        step(1'b1, 1'b0, 1'b0);
        run(63, 1'b1, 1'b0);
        push_exp("err_wins", ST_SLIP, 1, 0, 3, 2, e(41));
        step(1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b0);
        push_exp("hunt4", ST_HUNT, 0, 0, 4, 2, e(41));
        step(1'b1, 1'b0, 1'b0);
        run(63, 1'b1, 1'b0);
        push_exp("relock2", ST_LOCKED, 0, 1, 4, 2, e(41));
        step(1'b1, 1'b1, 1'b0);

        // enable dropped while locked, and mid-hunt (counters must clear)
        push_exp("en_drop", ST_HUNT, 0, 0, 4, 2, e(41));
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        push_exp("en_low_hold", ST_HUNT, 0, 0, 4, 2, e(41));
        step(1'b0, 1'b1, 1'b1);
        run(40, 1'b1, 1'b0);
        push_exp("en_drop_hunt", ST_HUNT, 0, 0, 4, 2, e(41));
        step(1'b0, 1'b1, 1'b0);
        run(62, 1'b1, 1'b0);
        push_exp("no_early_lock", ST_HUNT, 0, 0, 4, 2, e(41));
        step(1'b1, 1'b1, 1'b0);
        push_exp("relock3", ST_LOCKED, 0, 1, 4, 2, e(41));
        step(1'b1, 1'b1, 1'b0);
        chk("pulses_enable", pulse_cnt, 4);

        // Unlock, then reset while in WAIT
        run(3, 1'b1, 1'b1);
        push_exp("unlock2", ST_SLIP, 1, 0, 4, 3, e(45));
        step(1'b1, 1'b1, 1'b1);
        push_exp("wait_pre_reset", ST_WAIT, 0, 0, 5, 3, e(45));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        push_exp("reset_in_wait", ST_HUNT, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        run(11, 1'b0, 1'b0);
        push_exp("post_reset_idle", ST_HUNT, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("pulses_reset", pulse_cnt, 5);

        // Nine forced slips: slip_pos 1..7,0,1
        for (int k = 0; k < 9; k++) begin
            push_exp("forced_slip", ST_SLIP, 1, 0, k % 8, 0, 0);
            step(1'b1, 1'b1, 1'b1);
            push_exp("slip_pos", ST_WAIT, 0, 0, (k + 1) % 8, 0, 0);
            step(1'b1, 1'b0, 1'b0);
            run(7, 1'b0, 1'b0);
            push_exp("slip_hunt", ST_HUNT, 0, 0, (k + 1) % 8, 0, 0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("pulses_total", pulse_cnt, 14);
        chk("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
